im_loader: RTL and testbench

//   Boot loader that fills the instruction memory over its write port (WE, W_Ins, PC).

---
 rtl/im_loader.sv | 181 ++++++++++++++++++
 tb/tb_im_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module   : im_loader
// Purpose  : Boot loader for the instruction memory. Receives a byte stream
//            from a host link over a valid/ready handshake and writes it into
//            the IM through its write port (WE, PC, W_Ins), holding the CPU
//            off (BUSY) while a load is in progress.
//            Stream format, all fields MSB-first:
//              32-bit word count N, followed by N 32-bit instruction words.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   IMEM_SIZE : IM depth in words; largest word count accepted
//   BASE_ADDR : byte address of the first loaded word (word-aligned)
// Ports
//   CLK      in   1   clock, all state on posedge
//   RST      in   1   synchronous active-high reset
//   START    in   1   one-cycle load request, honoured only when not BUSY
//   RX_DATA  in   8   incoming byte
//   RX_VALID in   1   RX_DATA valid; held by the source until accepted
//   RX_READY out  1   loader accepts a byte this cycle
//   WE       out  1   IM write enable, one-cycle pulse per word
//   PC       out 32   IM byte address of the write
//   W_Ins    out 32   instruction word to write
//   BUSY     out  1   load in progress
//   DONE     out  1   last load completed successfully (sticky)
//   ERR      out  1   last load rejected (sticky)
// ============================================================================
module im_loader #(
  parameter int unsigned IMEM_SIZE = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic        WE,
  output logic [31:0] PC,
  output logic [31:0] W_Ins,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam logic [31:0] IMEM_SIZE_W = 32'(IMEM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] sh_q,    sh_d;     // only the three older bytes need storing
  logic [1:0]  bcnt_q,  bcnt_d;   // bytes of the current word already taken
  logic [31:0] widx_q,  widx_d;
  logic [31:0] n_q,     n_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] wins_q,  wins_d;
  logic        done_q,  done_d;
  logic        err_q,   err_d;

  logic        rx_ready;
  logic        accept;
  logic        last_byte;
  logic [31:0] word_in;
  logic [31:0] widx_inc;

  assign rx_ready  = (state_q == S_HDR) || (state_q == S_DATA);
  assign accept    = RX_VALID && rx_ready;
  // The fourth byte completes the word straight from the input, so the word
  // is available on the same edge that accepts it.
  assign last_byte = accept && (bcnt_q == 2'd3);
  assign word_in   = {sh_q, RX_DATA};
  assign widx_inc  = widx_q + 32'd1;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcnt_d  = bcnt_q;
    widx_d  = widx_q;
    n_d     = n_q;
    pc_d    = pc_q;
    wins_d  = wins_q;
    done_d  = done_q;
    err_d   = err_q;

    if (accept) begin
      sh_d   = {sh_q[15:0], RX_DATA};
      bcnt_d = bcnt_q + 2'd1;   // wraps to 0 after the fourth byte
    end

    case (state_q)
      S_IDLE, S_FIN, S_FAIL: begin
        if (START) begin
          state_d = S_HDR;
          done_d  = 1'b0;
          err_d   = 1'b0;
          bcnt_d  = 2'd0;
          widx_d  = 32'd0;
        end
      end

      S_HDR: begin
        if (last_byte) begin
          n_d = word_in;
          if (word_in == 32'd0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else if (word_in > IMEM_SIZE_W) begin
            state_d = S_FAIL;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (last_byte) begin
          wins_d  = word_in;
          pc_d    = BASE_ADDR + (widx_q << 2);
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        widx_d = widx_inc;
        if (widx_inc == n_q) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      sh_q    <= 24'd0;
      bcnt_q  <= 2'd0;
      widx_q  <= 32'd0;
      n_q     <= 32'd0;
      pc_q    <= BASE_ADDR;
      wins_q  <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      widx_q  <= widx_d;
      n_q     <= n_d;
      pc_q    <= pc_d;
      wins_q  <= wins_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign RX_READY = rx_ready;
  assign WE       = (state_q == S_WRITE);
  assign BUSY     = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_WRITE);
  assign PC       = pc_q;
  assign W_Ins    = wins_q;
  assign DONE     = done_q;
  assign ERR      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_loader
// Purpose  : Self-checking bench for im_loader. Expected IM writes are queued
//            as streams are issued; a monitor compares every WE pulse against
//            the head of the queue. Status outputs are checked at fixed points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_im_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic        WE;
  logic [31:0] PC;
  logic [31:0] W_Ins;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];     // {PC, W_Ins} of each expected write
  logic [7:0]  stim[$];

  always #5 CLK = ~CLK;

  im_loader #(
    .IMEM_SIZE(128),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .RX_READY (RX_READY),
    .WE       (WE),
    .PC       (PC),
    .W_Ins    (W_Ins),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Write monitor
  always @(negedge CLK) begin : mon
    logic [63:0] e;
    if (RST === 1'b0 && WE === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: got PC=%h W_Ins=%h, expected no write", PC, W_Ins);
      end else begin
        e = exp_q.pop_front();
        check("we_pc", PC, e[63:32]);
        check("we_ins", W_Ins, e[31:0]);
      end
    end
  end

  task automatic start_pulse();
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  // Present one byte and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge CLK);
        RX_VALID = 1'b0;
      end
    end
    @(negedge CLK);
    RX_VALID = 1'b1;
    RX_DATA  = b;
    START    = with_start;
    n = 0;
    while (RX_READY !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got RX_READY=%b, expected 1", RX_READY);
    end
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  // Sends stim[]; returns at the negedge right after the last byte's edge.
  task automatic send_stream(input bit gaps);
    foreach (stim[i]) send_byte(stim[i], gaps, 1'b0);
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  task automatic load_two_word_stream();
    stim = '{8'h00, 8'h00, 8'h00, 8'h02,
             8'h20, 8'h01, 8'h00, 8'h05,
             8'h8C, 8'h02, 8'h00, 8'h04};
    exp_q.push_back({32'h0000_0000, 32'h2001_0005});
    exp_q.push_back({32'h0000_0004, 32'h8C02_0004});
  endtask

  initial begin
    RST      = 1'b1;
    START    = 1'b0;
    RX_VALID = 1'b1;
    RX_DATA  = 8'hAA;

    // 1: reset with RX_VALID asserted
    repeat (2) @(negedge CLK);
    check("rst_we", {31'd0, WE}, 32'd0);
    check("rst_ready", {31'd0, RX_READY}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    check("rst_err", {31'd0, ERR}, 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("idle_ready", {31'd0, RX_READY}, 32'd0);
    check("idle_busy", {31'd0, BUSY}, 32'd0);

    // 2: back-to-back two-word load (a consumed 0xAA would corrupt the header)
    start_pulse();
    check("hdr_busy", {31'd0, BUSY}, 32'd1);
    load_two_word_stream();
    send_stream(1'b0);                  // this negedge: second WE
    @(negedge CLK);
    check("t2_done", {31'd0, DONE}, 32'd1);
    check("t2_busy", {31'd0, BUSY}, 32'd0);
    check("t2_err", {31'd0, ERR}, 32'd0);
    check("t2_ready", {31'd0, RX_READY}, 32'd0);

    // 3: same stream with idle gaps
    start_pulse();
    load_two_word_stream();
    send_stream(1'b1);
    @(negedge CLK);
    check("t3_done", {31'd0, DONE}, 32'd1);
    check("t3_busy", {31'd0, BUSY}, 32'd0);

    // 4a: oversize header
    start_pulse();
    stim = '{8'h00, 8'h00, 8'h00, 8'h81};
    send_stream(1'b0);
    check("t4_err", {31'd0, ERR}, 32'd1);
    check("t4_err_done", {31'd0, DONE}, 32'd0);
    check("t4_err_busy", {31'd0, BUSY}, 32'd0);

    // 4b: boundary N = IMEM_SIZE accepted (abort after header via reset)
    start_pulse();
    check("t4_err_clr", {31'd0, ERR}, 32'd0);
    stim = '{8'h00, 8'h00, 8'h00, 8'h80};
    send_stream(1'b0);
    check("t4_max_busy", {31'd0, BUSY}, 32'd1);
    check("t4_max_err", {31'd0, ERR}, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;

    // 4c: empty load
    start_pulse();
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_stream(1'b0);
    check("t4_zero_done", {31'd0, DONE}, 32'd1);
    check("t4_zero_busy", {31'd0, BUSY}, 32'd0);

    // 5: reset part-way through word 0, then RST and START together
    start_pulse();
    stim = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hAB, 8'hCD};
    foreach (stim[i]) send_byte(stim[i], 1'b0, 1'b0);
    @(negedge CLK);
    RX_VALID = 1'b0;
    RST      = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("t5_busy", {31'd0, BUSY}, 32'd0);
    check("t5_ready", {31'd0, RX_READY}, 32'd0);
    check("t5_done", {31'd0, DONE}, 32'd0);
    @(negedge CLK);
    RST   = 1'b1;
    START = 1'b1;
    @(negedge CLK);
    RST   = 1'b0;
    START = 1'b0;
    check("t5_rst_start_busy", {31'd0, BUSY}, 32'd0);
    start_pulse();
    stim = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    send_stream(1'b0);
    @(negedge CLK);
    check("t5_done2", {31'd0, DONE}, 32'd1);

    // 6: START during DATA ignored; START in FIN restarts
    start_pulse();
    exp_q.push_back({32'h0000_0000, 32'h1122_3344});
    exp_q.push_back({32'h0000_0004, 32'h5566_7788});
    stim = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22};
    foreach (stim[i]) send_byte(stim[i], 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b1);
    stim = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_stream(1'b0);
    @(negedge CLK);
    check("t6_done", {31'd0, DONE}, 32'd1);
    start_pulse();
    @(negedge CLK);
    check("t6_restart_done", {31'd0, DONE}, 32'd0);
    check("t6_restart_busy", {31'd0, BUSY}, 32'd1);
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_stream(1'b0);
    check("t6_final_done", {31'd0, DONE}, 32'd1);

    repeat (4) @(negedge CLK);
    check("writes_outstanding", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
